// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard
// Purpose  : Decode-stage RAW hazard scoreboard with branch squash window.
//            Optional stall statistics counter enabled by HAZARD_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
    parameter int REG_AW     = 3,
    parameter int PIPE_DEPTH = 2,
    parameter int BR_BUBBLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue,
    input  logic [REG_AW-1:0] AA,
    input  logic [REG_AW-1:0] BA,
    input  logic [REG_AW-1:0] DA,
    input  logic              RW,
    input  logic              MA,
    input  logic              MB,
    input  logic [1:0]        BS,
    output logic              stall,
    output logic              DHS,
    output logic              flush,
    output logic              hazard_a,
    output logic              hazard_b
`ifdef HAZARD_STATS_EN
   ,output logic [15:0]       stall_cnt
`endif
);

    localparam int CNT_W = (BR_BUBBLES > 1) ? $clog2(BR_BUBBLES) : 1;
    localparam logic [CNT_W-1:0] c_cnt_load = CNT_W'(BR_BUBBLES - 1);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        BRANCH = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [PIPE_DEPTH-1:0] r_v;
    logic [REG_AW-1:0]  r_dst [PIPE_DEPTH];
    logic               w_idle;
    logic               w_accept;
    logic               w_match_a;
    logic               w_match_b;

    assign w_idle = (r_state == IDLE);

    always_comb begin
        w_match_a = 1'b0;
        w_match_b = 1'b0;
        for (int k = 0; k < PIPE_DEPTH; k++) begin
            if (r_v[k] && (r_dst[k] == AA)) w_match_a = 1'b1;
            if (r_v[k] && (r_dst[k] == BA)) w_match_b = 1'b1;
        end
    end

    // Register 0 is hardwired, so it never produces a hazard.
    assign hazard_a = issue & w_idle & ~MA & (AA != '0) & w_match_a;
    assign hazard_b = issue & w_idle & ~MB & (BA != '0) & w_match_b;
    assign stall    = hazard_a | hazard_b;
    assign DHS      = ~stall;
    assign w_accept = issue & ~stall & w_idle;
    assign flush    = (r_state == BRANCH);

    // Scoreboard keeps shifting while stalled; stalled slots enter as bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v <= '0;
            for (int k = 0; k < PIPE_DEPTH; k++) r_dst[k] <= '0;
        end else begin
            for (int k = PIPE_DEPTH - 1; k > 0; k--) begin
                r_v[k]   <= r_v[k-1];
                r_dst[k] <= r_dst[k-1];
            end
            r_v[0]   <= w_accept & RW & (DA != '0);
            r_dst[0] <= DA;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_accept && (BS != 2'b00)) begin
                    w_state_nxt = BRANCH;
                    w_cnt_nxt   = c_cnt_load;
                end
            end
            BRANCH: begin
                if (r_cnt == '0) w_state_nxt = IDLE;
                else             w_cnt_nxt   = r_cnt - 1'b1;
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              r_stall_cnt <= '0;
        else if (stall && (r_stall_cnt != 16'hFFFF)) r_stall_cnt <= r_stall_cnt + 16'd1;
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire
